// File: rtl/dfm_pkg.sv
// dfm_pkg: shared types and defaults for the gated-counter transfer slice.
//   xfer_state_t        : signal-domain handshake FSM states
//   DEFAULT_SYNC_STAGES : default depth of single-bit synchronisers
//   DEFAULT_CNT_WIDTH   : default counter/result width
package dfm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACKLO = 2'd2
    } xfer_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_WIDTH   = 32;

endpackage

// File: rtl/data_syn.sv
// data_syn: single-bit multi-flop synchroniser into the clk_i domain.
//   clk_i   : destination clock
//   rst_n_i : async active-low reset, clears every stage to 0
//   d_i     : asynchronous single-bit input
//   q_o     : synchronised output, STAGES cycles of latency
module data_syn #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/edge2en.sv
// edge2en: one-cycle rise/fall enables from an already-synchronous level.
//   clk_i   : clock
//   rst_n_i : async active-low reset, delayed copy resets to 0
//   d_i     : synchronous level
//   rise_o  : d_i high now, low last cycle
//   fall_o  : d_i low now, high last cycle
module edge2en (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic dly_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= d_i;
        end
    end

    assign rise_o = d_i & ~dly_q;
    assign fall_o = ~d_i & dly_q;

endmodule

// File: rtl/sig_cnt_xfer.sv
// sig_cnt_xfer: counts sig_clk_i cycles while a (synchronised) gate is high,
// freezes the count on gate fall and hands it to the clk_i domain through a
// 4-phase req/ack handshake.
//   sig_clk_i / sig_rst_n : counted clock and its async active-low reset
//   clk_i / rst_n_i       : destination clock and its async active-low reset
//   gate_i                : gate level from the clk_i domain
//   busy_o                : (sig) transfer in flight
//   cnt_valid_o           : (clk) one-cycle pulse, result registers updated
//   cnt_data_o            : (clk) count of the last completed gate
//   cnt_ovf_o             : (clk) count saturated during that gate
//   cnt_drop_o            : (clk) at least one earlier gate result was lost
module sig_cnt_xfer
    import dfm_pkg::*;
#(
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                 sig_clk_i,
    input  logic                 sig_rst_n,
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 gate_i,
    output logic                 busy_o,
    output logic                 cnt_valid_o,
    output logic [CNT_WIDTH-1:0] cnt_data_o,
    output logic                 cnt_ovf_o,
    output logic                 cnt_drop_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ---------------- signal domain ----------------
    logic gate_s, gate_rise, gate_fall, ack_s, req_s;

    data_syn #(.STAGES(SYNC_STAGES)) u_gate_syn (
        .clk_i   (sig_clk_i),
        .rst_n_i (sig_rst_n),
        .d_i     (gate_i),
        .q_o     (gate_s)
    );

    edge2en u_gate_edge (
        .clk_i   (sig_clk_i),
        .rst_n_i (sig_rst_n),
        .d_i     (gate_s),
        .rise_o  (gate_rise),
        .fall_o  (gate_fall)
    );

    // Acknowledge is simply the clk-side view of req looped back.
    data_syn #(.STAGES(SYNC_STAGES)) u_ack_syn (
        .clk_i   (sig_clk_i),
        .rst_n_i (sig_rst_n),
        .d_i     (req_s),
        .q_o     (ack_s)
    );

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Counter runs independently of the transfer FSM so a new gate can be
    // measured while the previous result is still crossing.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (gate_rise) begin
            cnt_d = CNT_ONE;
            ovf_d = 1'b0;
        end else if (gate_s) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    xfer_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
    logic                 hold_ovf_q, hold_ovf_d;
    logic                 hold_drop_q, hold_drop_d;
    logic                 drop_pend_q, drop_pend_d;
    logic                 req_q, req_d;

    // Hold registers only change in IDLE, so they are stable for the whole
    // time req is high; the clk side may sample them as a bus.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        hold_ovf_d  = hold_ovf_q;
        hold_drop_d = hold_drop_q;
        drop_pend_d = drop_pend_q;
        case (state_q)
            IDLE: begin
                if (gate_fall) begin
                    hold_cnt_d  = cnt_q;
                    hold_ovf_d  = ovf_q;
                    hold_drop_d = drop_pend_q;
                    drop_pend_d = 1'b0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (gate_fall) drop_pend_d = 1'b1;
                if (ack_s) state_d = ACKLO;
            end
            ACKLO: begin
                // A fall in the cycle that returns to IDLE still counts as lost.
                if (gate_fall) drop_pend_d = 1'b1;
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // req is a dedicated flop so the crossing sees a glitch-free level.
        req_d = (state_d == REQ);
    end

    always_ff @(posedge sig_clk_i or negedge sig_rst_n) begin
        if (!sig_rst_n) begin
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            hold_ovf_q  <= 1'b0;
            hold_drop_q <= 1'b0;
            drop_pend_q <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_ovf_q  <= hold_ovf_d;
            hold_drop_q <= hold_drop_d;
            drop_pend_q <= drop_pend_d;
            req_q       <= req_d;
        end
    end

    assign busy_o = (state_q != IDLE);

    // ---------------- clk domain ----------------
    data_syn #(.STAGES(SYNC_STAGES)) u_req_syn (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (req_q),
        .q_o     (req_s)
    );

    logic                 req_p_q;
    logic                 req_rise;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] data_q, data_d;
    logic                 ovf_out_q, ovf_out_d;
    logic                 drop_out_q, drop_out_d;

    assign req_rise = req_s & ~req_p_q;

    // hold_* -> data/ovf/drop paths are multi-bit crossings made safe by the
    // handshake; constrain them with a max-delay/false-path, not a synchroniser.
    always_comb begin
        valid_d    = req_rise;
        data_d     = data_q;
        ovf_out_d  = ovf_out_q;
        drop_out_d = drop_out_q;
        if (req_rise) begin
            data_d     = hold_cnt_q;
            ovf_out_d  = hold_ovf_q;
            drop_out_d = hold_drop_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_p_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_out_q  <= 1'b0;
            drop_out_q <= 1'b0;
        end else begin
            req_p_q    <= req_s;
            valid_q    <= valid_d;
            data_q     <= data_d;
            ovf_out_q  <= ovf_out_d;
            drop_out_q <= drop_out_d;
        end
    end

    assign cnt_valid_o = valid_q;
    assign cnt_data_o  = data_q;
    assign cnt_ovf_o   = ovf_out_q;
    assign cnt_drop_o  = drop_out_q;

endmodule

// File: tb/tb_sig_cnt_xfer.sv
// Testbench for sig_cnt_xfer: a 32-bit instance (a) and an 8-bit instance (b)
// share clocks and resets; each has its own gate.
module tb_sig_cnt_xfer;

    logic        sig_clk = 1'b0;
    logic        clk     = 1'b0;
    logic        sig_rst_n = 1'b0;
    logic        rst_n     = 1'b0;
    logic        gate_a = 1'b0;
    logic        gate_b = 1'b0;

    logic        busy_a, valid_a, ovf_a, drop_a;
    logic [31:0] data_a;
    logic        busy_b, valid_b, ovf_b, drop_b;
    logic [7:0]  data_b;

    int tests = 0;
    int fails = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;

    // sig 100 MHz, posedges at 5 mod 10; clk 50 MHz, posedges at 2 mod 10.
    always #5 sig_clk = ~sig_clk;
    initial begin
        #2;
        forever #10 clk = ~clk;
    end

    sig_cnt_xfer #(.CNT_WIDTH(32), .SYNC_STAGES(2)) dut_a (
        .sig_clk_i   (sig_clk),
        .sig_rst_n   (sig_rst_n),
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .gate_i      (gate_a),
        .busy_o      (busy_a),
        .cnt_valid_o (valid_a),
        .cnt_data_o  (data_a),
        .cnt_ovf_o   (ovf_a),
        .cnt_drop_o  (drop_a)
    );

    sig_cnt_xfer #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut_b (
        .sig_clk_i   (sig_clk),
        .sig_rst_n   (sig_rst_n),
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .gate_i      (gate_b),
        .busy_o      (busy_b),
        .cnt_valid_o (valid_b),
        .cnt_data_o  (data_b),
        .cnt_ovf_o   (ovf_b),
        .cnt_drop_o  (drop_b)
    );

    // Pulse counters, sampled away from the clk rising edge.
    always @(negedge clk) begin
        if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
        if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
    end

    // Gate high for exactly n sig edges (gate_s high for n cycles).
    task automatic gate_pulse(input bit sel, input int n);
        @(posedge sig_clk); #1;
        if (sel) gate_b = 1'b1; else gate_a = 1'b1;
        repeat (n) @(posedge sig_clk);
        #1;
        if (sel) gate_b = 1'b0; else gate_a = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input int base, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if ((sel ? vcnt_b : vcnt_a) > base) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_valid_timeout: got no cnt_valid_o pulse, required one", name);
        end
    endtask

    task automatic wait_idle(input bit sel, input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sig_clk);
            if ((sel ? busy_b : busy_a) === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("FAIL %s_idle_timeout: busy_o stuck 1, required 0", name);
        end
    endtask

    task automatic wait_busy(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge sig_clk); #1;
            if (busy_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_busy_timeout: busy_o never rose, required 1", name);
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got a=%b b=%b, required 0", busy_a, busy_b);
        end
        sig_rst_n = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (valid_a !== 1'b0 || data_a !== 32'd0 || ovf_a !== 1'b0 || drop_a !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_a: got v=%b d=%0d o=%b dr=%b, required all 0",
                     valid_a, data_a, ovf_a, drop_a);
        end
        tests++;
        if (valid_b !== 1'b0 || data_b !== 8'd0 || ovf_b !== 1'b0 || drop_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_b: got v=%b d=%0d o=%b dr=%b, required all 0",
                     valid_b, data_b, ovf_b, drop_b);
        end
    endtask

    task automatic test_basic();
        int base = vcnt_a;
        gate_pulse(1'b0, 1000);
        wait_valid(1'b0, base, "basic");
        tests++;
        if (data_a !== 32'd1000 || ovf_a !== 1'b0 || drop_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got d=%0d o=%b dr=%b, required d=1000 o=0 dr=0",
                     data_a, ovf_a, drop_a);
        end
        wait_idle(1'b0, "basic");
        repeat (20) @(negedge clk);
        tests++;
        if (vcnt_a !== base + 1) begin
            fails++;
            $display("FAIL basic_pulses: got %0d pulses, required 1", vcnt_a - base);
        end
    endtask

    task automatic test_saturate();
        int base = vcnt_b;
        gate_pulse(1'b1, 300);
        wait_valid(1'b1, base, "sat");
        tests++;
        if (data_b !== 8'd255 || ovf_b !== 1'b1 || drop_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_result: got d=%0d o=%b dr=%b, required d=255 o=1 dr=0",
                     data_b, ovf_b, drop_b);
        end
        wait_idle(1'b1, "sat");
        gate_pulse(1'b1, 10);
        wait_valid(1'b1, base + 1, "sat_next");
        tests++;
        if (data_b !== 8'd10 || ovf_b !== 1'b0 || drop_b !== 1'b0) begin
            fails++;
            $display("FAIL sat_next_result: got d=%0d o=%b dr=%b, required d=10 o=0 dr=0",
                     data_b, ovf_b, drop_b);
        end
        wait_idle(1'b1, "sat_next");
    endtask

    task automatic test_drop();
        int base = vcnt_a;
        gate_pulse(1'b0, 8);
        gate_pulse(1'b0, 2);   // falls a few sig cycles later, while REQ is pending
        wait_valid(1'b0, base, "drop_first");
        tests++;
        if (data_a !== 32'd8 || ovf_a !== 1'b0 || drop_a !== 1'b0) begin
            fails++;
            $display("FAIL drop_first_result: got d=%0d o=%b dr=%b, required d=8 o=0 dr=0",
                     data_a, ovf_a, drop_a);
        end
        wait_idle(1'b0, "drop_first");
        repeat (30) @(negedge clk);
        tests++;
        if (vcnt_a !== base + 1) begin
            fails++;
            $display("FAIL drop_lost: got %0d pulses, required 1", vcnt_a - base);
        end
        gate_pulse(1'b0, 12);
        wait_valid(1'b0, base + 1, "drop_third");
        tests++;
        if (data_a !== 32'd12 || ovf_a !== 1'b0 || drop_a !== 1'b1) begin
            fails++;
            $display("FAIL drop_third_result: got d=%0d o=%b dr=%b, required d=12 o=0 dr=1",
                     data_a, ovf_a, drop_a);
        end
        wait_idle(1'b0, "drop_third");
    endtask

    task automatic test_back_to_back();
        int base = vcnt_a;
        gate_pulse(1'b0, 7);
        repeat (2) @(posedge sig_clk);
        gate_pulse(1'b0, 500);   // re-rises while the 7-count transfer is in flight
        tests++;
        if (vcnt_a !== base + 1 || data_a !== 32'd7) begin
            fails++;
            $display("FAIL b2b_first: got pulses=%0d d=%0d, required pulses=1 d=7",
                     vcnt_a - base, data_a);
        end
        wait_valid(1'b0, base + 1, "b2b_second");
        tests++;
        if (data_a !== 32'd500 || ovf_a !== 1'b0 || drop_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_result: got d=%0d o=%b dr=%b, required d=500 o=0 dr=0",
                     data_a, ovf_a, drop_a);
        end
        wait_idle(1'b0, "b2b");
    endtask

    task automatic test_sig_reset();
        int base = vcnt_a;
        gate_pulse(1'b0, 15);
        wait_busy("sigrst");
        sig_rst_n = 1'b0;
        repeat (2) @(posedge sig_clk);
        #1 sig_rst_n = 1'b1;
        repeat (60) @(negedge clk);
        tests++;
        if (vcnt_a !== base || busy_a !== 1'b0) begin
            fails++;
            $display("FAIL sigrst_no_valid: got pulses=%0d busy=%b, required pulses=0 busy=0",
                     vcnt_a - base, busy_a);
        end
        gate_pulse(1'b0, 20);
        wait_valid(1'b0, base, "sigrst_after");
        tests++;
        if (data_a !== 32'd20 || drop_a !== 1'b0) begin
            fails++;
            $display("FAIL sigrst_after_result: got d=%0d dr=%b, required d=20 dr=0",
                     data_a, drop_a);
        end
        wait_idle(1'b0, "sigrst_after");
    endtask

    task automatic test_clk_reset();
        int base = vcnt_a;
        gate_pulse(1'b0, 25);
        wait_busy("clkrst");
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        tests++;
        if (vcnt_a !== base + 1 || data_a !== 32'd25) begin
            fails++;
            $display("FAIL clkrst_recapture: got pulses=%0d d=%0d, required pulses=1 d=25",
                     vcnt_a - base, data_a);
        end
        wait_idle(1'b0, "clkrst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_drop();
        test_back_to_back();
        test_sig_reset();
        test_clk_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
